// File: rtl/fifo_generator.sv
// Single-clock first-word-fall-through FIFO with registered overflow/underflow pulses.
// Optional stored-word count output enabled by defining FIFO_DATA_COUNT_EN.
module fifo_generator #(
    parameter int  DATA_WIDTH = 512,
    parameter int  DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_DATA_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   data_count
`endif
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    // A write while full is dropped even when a read frees a slot in the same cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // NOTE: the storage array has no reset; contents are only ever observed through
    // rd_ptr while count says they are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[rd_ptr];
        end
    end

`ifdef FIFO_DATA_COUNT_EN
    assign data_count = count;
`endif

endmodule

// File: tb/tb_fifo_generator.sv
// Scoreboard bench for fifo_generator: a reference queue models contents and flags,
// and every DUT output is compared against it each cycle.
module tb_fifo_generator;

    localparam int DATA_WIDTH = 512;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_DATA_COUNT_EN
    logic [ADDR_WIDTH:0]   data_count;
`endif

    fifo_generator #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef FIFO_DATA_COUNT_EN
        ,
        .data_count(data_count)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] sb_q[$];
    logic                  exp_ovf;
    logic                  exp_unf;
    int                    n_checks;
    int                    n_fail;

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] act,
                         input logic [DATA_WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare all outputs against the model; called on the falling edge.
    task automatic check_outputs();
        logic [DATA_WIDTH-1:0] exp_dout;
        exp_dout = (sb_q.size() > 0) ? sb_q[0] : '0;
        check("empty", DATA_WIDTH'(empty), DATA_WIDTH'(sb_q.size() == 0));
        check("full", DATA_WIDTH'(full), DATA_WIDTH'(sb_q.size() == DEPTH));
        check("dout", dout, exp_dout);
        check("overflow", DATA_WIDTH'(overflow), DATA_WIDTH'(exp_ovf));
        check("underflow", DATA_WIDTH'(underflow), DATA_WIDTH'(exp_unf));
`ifdef FIFO_DATA_COUNT_EN
        check("data_count", DATA_WIDTH'(data_count), DATA_WIDTH'(sb_q.size()));
`endif
    endtask

    // One clock cycle: check current outputs, drive a request, advance the model.
    task automatic step(input logic wr, input logic rd, input logic [DATA_WIDTH-1:0] d);
        logic                  was_full;
        logic                  was_empty;
        logic [DATA_WIDTH-1:0] popped;
        check_outputs();
        was_full  = (sb_q.size() == DEPTH);
        was_empty = (sb_q.size() == 0);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        if (rd && !was_empty) begin
            popped = sb_q.pop_front();
            check("pop_data", dout, popped);
        end
        if (wr && !was_full) begin
            sb_q.push_back(d);
        end
        exp_ovf = wr && was_full;
        exp_unf = rd && was_empty;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
        resetn = 1'b0;
        sb_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        resetn   = 1'b0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        @(negedge clk);
        apply_reset();

        // Idle after reset: no pulses, output zero.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

        // Single word fall-through then pop.
        step(1'b1, 1'b0, DATA_WIDTH'(32'hA5));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Fill 1..16, one overflow attempt, drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DATA_WIDTH'(i));
        step(1'b1, 1'b0, DATA_WIDTH'(17));
        step(1'b1, 1'b1, DATA_WIDTH'(18));
        step(1'b0, 1'b0, '0);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Underflow pulses, repeated while the request persists.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, DATA_WIDTH'(32'h33));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Half full, then simultaneous read/write across the pointer wrap.
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 1'b0, DATA_WIDTH'(100 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DATA_WIDTH'(200 + i));
        for (int i = 0; i < DEPTH / 2; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Reset mid-stream with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_WIDTH'(300 + i));
        apply_reset();
        step(1'b1, 1'b0, DATA_WIDTH'(32'h77));
        step(1'b1, 1'b0, DATA_WIDTH'(32'h78));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Random traffic with wide data.
        for (int i = 0; i < 300; i++) begin
            logic [DATA_WIDTH-1:0] d;
            for (int k = 0; k < DATA_WIDTH / 32; k++) d[k*32 +: 32] = $urandom();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_generator.md
# fifo_generator

Single-clock, first-word-fall-through (FWFT) FIFO, DATA_WIDTH bits wide and DEPTH entries deep. It buffers 512-bit DRAM-burst words between the pixel-buffer gearbox that produces them and the DRAM write engine that consumes them. The head word is always presented on `dout` while the FIFO is non-empty; a read pops that word. Overflow and underflow attempts are flagged, never corrupt state.

## Interface
- `DATA_WIDTH`, default 512: word width in bits.
- `DEPTH`, default 16: number of entries; must be a power of two and at least 2.
- `ADDR_WIDTH`, default `$clog2(DEPTH)`: derived, not overridden.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `din`  in  DATA_WIDTH  write data.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read (pop) request.
- `dout`  out  DATA_WIDTH  head-of-FIFO word (FWFT).
- `empty`  out  1  no stored words.
- `full`  out  1  DEPTH words stored.
- `overflow`  out  1  one-cycle pulse: previous cycle's write was rejected.
- `underflow`  out  1  one-cycle pulse: previous cycle's read was rejected.
- `data_count`  out  ADDR_WIDTH+1  stored-word count; present only with `FIFO_DATA_COUNT_EN`.

## Operation
- Storage is a DEPTH×DATA_WIDTH array. It is not reset.
- State registers:
  - `wr_ptr` and `rd_ptr`, ADDR_WIDTH bits each; they wrap modulo DEPTH naturally.
  - `count`, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Write accepted when `wr_en && !full`: stores `din` at `wr_ptr`, then `wr_ptr` increments.
- Read accepted when `rd_en && !empty`: `rd_ptr` increments; the popped word is the one shown on `dout` in that cycle.
- Write while full is dropped, even if a read is accepted in the same cycle. Pointers and storage are unchanged, and `overflow` pulses.
- Read while empty is ignored; `underflow` pulses.
- Count update:
  - accepted write only: `count`+1
  - accepted read only: `count`−1
  - both accepted: unchanged
- Flags and output, all combinational from registers:
  - `empty` = (`count`==0)
  - `full` = (`count`==DEPTH)
  - `dout` = storage[`rd_ptr`] when !`empty`, else all zeros

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system) drives:
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0
  - `empty`=1, `full`=0, `dout`=0
  - `overflow`=0, `underflow`=0
  - `data_count`=0 when configured
- Write-to-read latency: after the edge that accepts a write into an empty FIFO, `empty` falls and `dout` shows that word. No additional cycle.
- Read latency: after the accepting edge, `dout` shows the next word, or 0 with `empty`=1 if none remains.
- `full` rises after the edge that stores word DEPTH. It falls after the first accepted read.
- `overflow`/`underflow` are registered: high for exactly one cycle after each offending request cycle. They repeat each cycle the request persists.
- Pointer wrap from DEPTH−1 to 0 requires no special handling; ordering is preserved across the wrap.
- Reset asserted mid-operation discards all contents immediately; flags take their reset values asynchronously.

## Configuration
- `FIFO_DATA_COUNT_EN`:
  - Defined: the module exposes output `data_count` equal to the internal `count` (same timing as the flags).
  - Undefined: the port and any dedicated logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset then idle: `empty`=1, `full`=0, `dout`=0, no flag pulses. Assert `resetn`=0 mid-stream with 5 words stored → `empty`=1 immediately, next write/read sequence starts at entry 0.
- Write 0xA5 (zero-extended) once → next cycle `empty`=0, `dout`=0xA5. Pulse `rd_en` → next cycle `empty`=1, `dout`=0.
- Write values 1..16 (DEPTH=16) → `full`=1 after the 16th edge. 17th write → `overflow` pulse, contents unchanged. Reads then return 1..16 in order, and `empty`=1 after the 16th read.
- Read while empty → `underflow` one-cycle pulse, pointers unchanged. Subsequent write/read returns the correct data.
- Half-full (8 words), simultaneous `wr_en`/`rd_en` for 20 cycles with an incrementing pattern → count stays 8, output order is exact across pointer wrap, no flag pulses.
- With `FIFO_DATA_COUNT_EN`: `data_count` tracks 0→16→0 through fill/drain and stays constant during simultaneous read/write. Without the macro: compiles with no `data_count` port.
